// File: rtl/timer_pkg.sv
// Shared definitions for the push-button controller.
//
// Contents:
//   btn_state_t      - per-channel FSM state encoding (IDLE, ARM, HELD, RPT, REL)
//   DEF_*_TICKS      - default tick counts for debounce, hold and auto-repeat
//   max3 / cnt_width - helpers that size the per-channel tick counter
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        HELD = 3'd2,
        RPT  = 3'd3,
        REL  = 3'd4
    } btn_state_t;

    localparam int DEF_DB_TICKS     = 16;
    localparam int DEF_HOLD_TICKS   = 500;
    localparam int DEF_REPEAT_TICKS = 100;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One spare bit above clog2 so the largest terminal value always fits.
    function automatic int cnt_width(input int db, input int hold, input int rpt);
        return $clog2(max3(db, hold, rpt)) + 1;
    endfunction

endpackage

// File: rtl/btn_fsm.sv
// Per-channel debounce / hold / auto-repeat state machine.
//
// Ports:
//   in_clk       - system clock, rising edge
//   rst          - synchronous active-high reset
//   tick_en      - sample strobe; the FSM and its counter move only when high
//   raw_s        - synchronized button level (1 = pressed)
//   level        - debounced button state (1 in HELD, RPT, REL)
//   press_pulse  - one-cycle pulse when a press is accepted
//   repeat_pulse - one-cycle pulse for each auto-repeat event
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | released and stable
// ARM   | pressed seen, counting DB_TICKS equal samples to accept it
// HELD  | accepted press, counting HOLD_TICKS towards auto-repeat
// RPT   | auto-repeating, one repeat_pulse every REPEAT_TICKS
// REL   | release seen, counting DB_TICKS equal samples to accept it
module btn_fsm
    import timer_pkg::*;
#(
    parameter int DB_TICKS     = DEF_DB_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int CNT_W        = cnt_width(DEF_DB_TICKS, DEF_HOLD_TICKS, DEF_REPEAT_TICKS)
) (
    input  logic in_clk,
    input  logic rst,
    input  logic tick_en,
    input  logic raw_s,
    output logic level,
    output logic press_pulse,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_TICKS - 1);

    btn_state_t       state;
    logic [CNT_W-1:0] cnt;

    // level is updated on the two transitions that cross the IDLE/ARM vs
    // HELD/RPT/REL boundary, so it always matches the registered state.
    always_ff @(posedge in_clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            level        <= 1'b0;
            press_pulse  <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            press_pulse  <= 1'b0;
            repeat_pulse <= 1'b0;
            if (tick_en) begin
                case (state)
                    IDLE: begin
                        if (raw_s) begin
                            state <= ARM;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt   <= '0;
                        end
                    end
                    ARM: begin
                        if (!raw_s) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state       <= HELD;
                            cnt         <= '0;
                            level       <= 1'b1;
                            press_pulse <= 1'b1;
                        end else begin
                            cnt   <= cnt + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!raw_s) begin
                            state <= REL;
                            cnt   <= CNT_ONE;
                        end else if (cnt == HOLD_LAST) begin
                            state        <= RPT;
                            cnt          <= '0;
                            repeat_pulse <= 1'b1;
                        end else begin
                            cnt   <= cnt + CNT_ONE;
                        end
                    end
                    RPT: begin
                        if (!raw_s) begin
                            state <= REL;
                            cnt   <= CNT_ONE;
                        end else if (cnt == RPT_LAST) begin
                            cnt          <= '0;
                            repeat_pulse <= 1'b1;
                        end else begin
                            cnt   <= cnt + CNT_ONE;
                        end
                    end
                    REL: begin
                        // A bounce back to pressed resumes the hold phase
                        // without announcing a new press.
                        if (raw_s) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == DB_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                            level <= 1'b0;
                        end else begin
                            cnt   <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/button_ctrl.sv
// Multi-channel push-button controller: synchronizes raw button levels and
// runs one debounce / hold / auto-repeat FSM per channel.
//
// Ports:
//   in_clk       - system clock, rising edge
//   rst          - synchronous active-high reset
//   tick_en      - one-cycle sample strobe from the debounce divider
//   btn_raw      - raw asynchronous button levels, 1 = pressed
//   btn_level    - debounced button state per channel
//   press_pulse  - one-cycle pulse per accepted press
//   repeat_pulse - one-cycle pulse per auto-repeat event
module button_ctrl
    import timer_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int DB_TICKS     = DEF_DB_TICKS,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic             in_clk,
    input  logic             rst,
    input  logic             tick_en,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] repeat_pulse
);

    localparam int CNT_W = cnt_width(DB_TICKS, HOLD_TICKS, REPEAT_TICKS);

    logic [N_BTN-1:0] sync_meta;
    logic [N_BTN-1:0] raw_s;

    // Two-flop synchronizer; it runs every cycle, independent of tick_en.
    always_ff @(posedge in_clk) begin
        if (rst) begin
            sync_meta <= '0;
            raw_s     <= '0;
        end else begin
            sync_meta <= btn_raw;
            raw_s     <= sync_meta;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_fsm #(
            .DB_TICKS     (DB_TICKS),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS),
            .CNT_W        (CNT_W)
        ) u_fsm (
            .in_clk       (in_clk),
            .rst          (rst),
            .tick_en      (tick_en),
            .raw_s        (raw_s[i]),
            .level        (btn_level[i]),
            .press_pulse  (press_pulse[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end

endmodule
